// File: rtl/sram_responder_if.sv
// sram_responder_if -- CPU SRAM-style bus between an initiator and the
// sram_responder array.
//
// Signals:
//   sram_en    : access request this cycle (one access per cycle, no stall)
//   sram_wen   : byte write enables, bit i covers sram_wdata[8i+7:8i];
//                4'b0000 with sram_en=1 is a read
//   sram_addr  : byte address
//   sram_wdata : write data
//   sram_rdata : registered read data, valid one cycle after the access
//
// Handshake: there is no valid/ready pair. Every cycle with sram_en=1 is
// exactly one accepted access, and its read data appears on sram_rdata in
// the following cycle.
interface sram_responder_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder -- single-port 32-bit SRAM responder with byte-lane writes,
// read-first behaviour, a sticky out-of-range flag and saturating access
// counters.
//
// Ports:
//   clk      : clock, all state changes on the rising edge
//   resetn   : synchronous active-low reset
//   bus      : sram_responder_if.slave (en/wen/addr/wdata in, rdata out)
//   addr_err : sticky flag, set by any out-of-range access, cleared by reset
//   rd_cnt   : saturating count of accepted in-range reads
//   wr_cnt   : saturating count of accepted in-range writes
//
// Parameters:
//   ADDR_W : word-address width, depth = 2**ADDR_W words
//   BASE   : byte base address, low ADDR_W+2 bits are zero
module sram_responder #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             resetn,
  sram_responder_if.slave  bus,
  output logic             addr_err,
  output logic [15:0]      rd_cnt,
  output logic [15:0]      wr_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  // Byte span of the array; 33 bits so ADDR_W up to 30 cannot overflow.
  localparam logic [32:0] SPAN = 33'd4 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdata_q;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              acc_rd;
  logic              acc_wr;

  // Addresses below BASE wrap to large offsets and fall out of range.
  assign offset   = bus.sram_addr - BASE;
  assign idx      = offset[ADDR_W+1:2];
  assign in_range = ({1'b0, offset} < SPAN);
  assign acc_wr   = resetn && bus.sram_en && in_range && (bus.sram_wen != 4'b0000);
  assign acc_rd   = resetn && bus.sram_en && in_range && (bus.sram_wen == 4'b0000);

  assign bus.sram_rdata = rdata_q;

  // Array storage is never reset; writes are blocked while resetn is low.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sram_wen[i]) begin
          mem[idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read-first: rdata_q samples the word before this edge's write lands.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q  <= 32'h0000_0000;
      addr_err <= 1'b0;
      rd_cnt   <= 16'h0000;
      wr_cnt   <= 16'h0000;
    end else begin
      if (bus.sram_en) begin
        if (in_range) begin
          rdata_q <= mem[idx];
        end else begin
          rdata_q  <= 32'h0000_0000;
          addr_err <= 1'b1;
        end
      end
      if (acc_rd && (rd_cnt != 16'hFFFF)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (acc_wr && (wr_cnt != 16'hFFFF)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder -- randomized and directed stimulus for sram_responder
// with a word-array reference model and an expected-data queue.
module tb_sram_responder;

  localparam int          ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sram_responder_if bus ();
  logic        addr_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  sram_responder #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .addr_err (addr_err),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem   [DEPTH];
  logic [3:0]  m_known [DEPTH];   // per-byte "has been written" mask
  logic [31:0] m_rdata;
  logic        m_rdata_known;
  logic        m_err;
  int          m_rd;
  int          m_wr;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of the behavioural rules to the model.
  task automatic model_step(input logic rst_n, input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
    longint unsigned off;
    int idx;
    if (!rst_n) begin
      m_rdata = 0; m_rdata_known = 1'b1; m_err = 1'b0; m_rd = 0; m_wr = 0;
      return;
    end
    if (!en) return;
    off = longint'(addr - BASE) & 64'hFFFF_FFFF;
    if (off >= longint'(4 * DEPTH)) begin
      m_err = 1'b1; m_rdata = 0; m_rdata_known = 1'b1;
      return;
    end
    idx = int'(off / 4);
    m_rdata       = m_mem[idx];
    m_rdata_known = (m_known[idx] == 4'hF);
    if (wen == 4'b0000) begin
      if (m_rd < 65535) m_rd++;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) begin
          m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
          m_known[idx][b] = 1'b1;
        end
      end
      if (m_wr < 65535) m_wr++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic rst_n, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input string tag, input bit do_chk);
    @(negedge clk);
    resetn         = rst_n;
    bus.sram_en    = en;
    bus.sram_wen   = wen;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
    model_step(rst_n, en, wen, addr, wdata);
    exp_q.push_back(m_rdata);
    @(posedge clk);
    #1;
    if (do_chk) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      if (m_rdata_known) check({tag, ".rdata"}, bus.sram_rdata, e);
      check({tag, ".err"}, {31'd0, addr_err}, {31'd0, m_err});
      check({tag, ".rd"},  {16'd0, rd_cnt}, 32'(m_rd));
      check({tag, ".wr"},  {16'd0, wr_cnt}, 32'(m_wr));
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input string tag);
    cycle(1'b1, 1'b1, w, a, d, tag, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    cycle(1'b1, 1'b1, 4'b0000, a, $urandom, tag, 1'b1);
  endtask

  task automatic idle(input string tag);
    cycle(1'b1, 1'b0, 4'($urandom), $urandom, $urandom, tag, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 32'h0; m_known[i] = 4'h0;
    end
    m_rdata = 0; m_rdata_known = 1'b1; m_err = 0; m_rd = 0; m_wr = 0;
    resetn = 1'b0; bus.sram_en = 1'b0; bus.sram_wen = 4'h0;
    bus.sram_addr = 32'h0; bus.sram_wdata = 32'h0;

    // reset state
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "rst0", 1'b1);
    cycle(1'b0, 1'b1, 4'hF, 32'h0, 32'hDEAD_BEEF, "rst1", 1'b1);

    // full-word write then read
    wr(BASE + 32'd8, 32'h1234_5678, 4'hF, "fw_wr");
    rd(BASE + 32'd8, "fw_rd");
    check("fw_value", bus.sram_rdata, 32'h1234_5678);
    check("fw_cnts", {rd_cnt, wr_cnt}, {16'd1, 16'd1});

    // byte lanes
    wr(BASE + 32'd8, 32'hAABB_CCDD, 4'b0101, "bl_wr");
    rd(BASE + 32'd9, "bl_rd");   // low address bits ignored
    check("bl_value", bus.sram_rdata, 32'h12BB_56DD);

    // read-first write, then immediate read of new data
    wr(BASE + 32'd16, 32'h1111_1111, 4'hF, "rf_init");
    wr(BASE + 32'd16, 32'h2222_2222, 4'hF, "rf_wr");
    check("rf_old", bus.sram_rdata, 32'h1111_1111);
    rd(BASE + 32'd16, "rf_rd");
    check("rf_new", bus.sram_rdata, 32'h2222_2222);

    // idle hold
    wr(BASE + 32'd24, 32'hCAFE_F00D, 4'hF, "id_wr");
    rd(BASE + 32'd24, "id_rd");
    for (int i = 0; i < 5; i++) idle("id_hold");
    check("id_value", bus.sram_rdata, 32'hCAFE_F00D);

    // randomized in-range traffic, clustered on a few words to hit RAW hazards
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = BASE + {$urandom_range(0, 15), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      case ($urandom_range(0, 3))
        0: idle("rnd_idle");
        1: rd(a, "rnd_rd");
        default: wr(a, $urandom, 4'($urandom), "rnd_wr");
      endcase
    end

    // reset mid-run with an access pending
    wr(BASE + 32'd32, 32'h5A5A_A5A5, 4'hF, "mr_wr");
    rd(BASE + 32'd32, "mr_rd");
    cycle(1'b0, 1'b1, 4'hF, BASE + 32'd32, 32'h0BAD_0BAD, "mr_rst", 1'b1);
    check("mr_zero", {bus.sram_rdata[15:0], rd_cnt, wr_cnt[0], addr_err}, 34'h0);
    rd(BASE + 32'd32, "mr_after");
    check("mr_kept", bus.sram_rdata, 32'h5A5A_A5A5);

    // out-of-range: just past the end, and a wrapped address below BASE+0
    wr(BASE, 32'h0F0F_F0F0, 4'hF, "oor_init");
    rd(BASE + 32'd8, "oor_pre");
    wr(BASE + 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, "oor_wr");
    check("oor_rdata", bus.sram_rdata, 32'h0);
    check("oor_err", {31'd0, addr_err}, 32'd1);
    rd(BASE, "oor_word0");
    check("oor_word0_val", bus.sram_rdata, 32'h0F0F_F0F0);
    rd(BASE - 32'd4, "oor_wrap");
    for (int i = 0; i < 100; i++) idle("oor_sticky");
    check("oor_err_held", {31'd0, addr_err}, 32'd1);

    // saturation of the read counter
    for (int i = 0; i < 70000; i++) cycle(1'b1, 1'b1, 4'h0, BASE + 32'd24, 32'h0, "sat", 1'b0);
    idle("sat_end");
    check("sat_rd", {16'd0, rd_cnt}, 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
